req_arbiter: RTL and testbench



---
 rtl/req_arbiter.sv | 127 ++++++++++++
 tb/tb_req_arbiter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/req_arbiter.sv
// req_arbiter: N-way request arbiter with fixed-priority and round-robin modes.
// The grant is registered and one-hot, and it stays with its owner while the
// owner keeps requesting. When other requesters are waiting, the owner is
// forced to rotate after MAX_HOLD consecutive cycles.
module req_arbiter #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 8,
   parameter int IDW      = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           mode,
   input  logic [N-1:0]   req,
   output logic [N-1:0]   gnt,
   output logic           gnt_valid,
   output logic [IDW-1:0] gnt_id
);

   localparam int HW = $clog2(MAX_HOLD + 1);

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   state_t         state;
   logic [IDW-1:0] rr_ptr;
   logic [HW-1:0]  hold_cnt;

   logic [N-1:0]   cand;
   logic           cand_any;
   logic [IDW-1:0] win_fp;
   logic [IDW-1:0] win_rr;
   logic [IDW-1:0] win;
   logic           rr_found;
   int unsigned    scan_idx;
   logic [N-1:0]   win_oh;
   logic [IDW-1:0] win_next;
   logic           owner_req;
   logic           hold_full;
   logic           do_grant;
   logic           do_drop;

   // gnt is the one-hot code of the owner in GRANT and zero in IDLE.
   // Masking req with ~gnt therefore excludes the current owner, and it is
   // a no-op when the arbiter is idle.
   assign cand     = req & ~gnt;
   assign cand_any = |cand;

   // Winner search: highest set index, or the first set index found
   // scanning upward from rr_ptr with wrap-around.
   always_comb begin
      win_fp   = '0;
      win_rr   = '0;
      rr_found = 1'b0;
      scan_idx = 0;
      for (int unsigned i = 0; i < N; i++) begin
         if (cand[IDW'(i)]) win_fp = IDW'(i);
      end
      for (int unsigned i = 0; i < N; i++) begin
         scan_idx = (32'(rr_ptr) + i) % N;
         if (!rr_found && cand[IDW'(scan_idx)]) begin
            win_rr   = IDW'(scan_idx);
            rr_found = 1'b1;
         end
      end
      win = mode ? win_rr : win_fp;
   end

   // One-hot code of the winner, and the pointer value that follows it.
   always_comb begin
      win_oh = '0;
      for (int unsigned i = 0; i < N; i++) begin
         win_oh[i] = (IDW'(i) == win);
      end
      win_next = (win == IDW'(N - 1)) ? '0 : win + IDW'(1);
   end

   // Decide whether this cycle takes a new winner or drops to idle.
   always_comb begin
      owner_req = req[gnt_id];
      hold_full = (hold_cnt >= HW'(MAX_HOLD));
      do_grant  = 1'b0;
      do_drop   = 1'b0;
      case (state)
         IDLE:    do_grant = cand_any;
         GRANT: begin
            if (!owner_req) begin
               do_grant = cand_any;
               do_drop  = !cand_any;
            end else if (hold_full) begin
               do_grant = cand_any;
            end
         end
         default: do_drop = 1'b1;
      endcase
   end

   // Arbiter FSM with registered grant outputs, rotation pointer and hold counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         gnt       <= '0;
         gnt_valid <= 1'b0;
         gnt_id    <= '0;
         rr_ptr    <= '0;
         hold_cnt  <= '0;
      end else if (do_grant) begin
         state     <= GRANT;
         gnt       <= win_oh;
         gnt_valid <= 1'b1;
         gnt_id    <= win;
         rr_ptr    <= win_next;
         hold_cnt  <= HW'(1);
      end else if (do_drop) begin
         state     <= IDLE;
         gnt       <= '0;
         gnt_valid <= 1'b0;
      end else if (state == GRANT) begin
         // The owner keeps the grant. At the limit with nobody waiting,
         // the count restarts instead of the grant being dropped.
         if (hold_full) hold_cnt <= HW'(1);
         else           hold_cnt <= hold_cnt + HW'(1);
      end
   end

endmodule

// File: tb/tb_req_arbiter.sv
// tb_req_arbiter: directed scoreboard bench for req_arbiter.
// dut_a uses MAX_HOLD=8 and dut_b uses MAX_HOLD=1. Both see the same inputs.
module tb_req_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       mode = 1'b0;
   logic [3:0] req = 4'b1111;

   logic [3:0] gnt_a, gnt_b;
   logic       gv_a, gv_b;
   logic [1:0] id_a, id_b;

   int checks = 0;
   int errors = 0;
   int stepn  = 0;

   typedef struct {
      logic [3:0] gnt_a;
      logic [1:0] id_a;
      logic       chk_b;
      logic [3:0] gnt_b;
   } exp_t;

   exp_t sb[$];

   req_arbiter #(.N(4), .MAX_HOLD(8)) dut_a (
      .clk(clk), .rst(rst), .mode(mode), .req(req),
      .gnt(gnt_a), .gnt_valid(gv_a), .gnt_id(id_a)
   );

   req_arbiter #(.N(4), .MAX_HOLD(1)) dut_b (
      .clk(clk), .rst(rst), .mode(mode), .req(req),
      .gnt(gnt_b), .gnt_valid(gv_b), .gnt_id(id_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %0h expected %0h", tag, stepn, act, exp);
      end
   endtask

   // Drive one cycle of inputs and queue the expected outputs. The outputs
   // are sampled 1 time unit after the edge and checked against the queue.
   task automatic step(input logic r, input logic m, input logic [3:0] rq,
                       input logic [3:0] eg, input logic [1:0] eid,
                       input logic cb, input logic [3:0] egb);
      exp_t e;
      rst = r;
      mode = m;
      req = rq;
      e.gnt_a = eg;
      e.id_a  = eid;
      e.chk_b = cb;
      e.gnt_b = egb;
      sb.push_back(e);
      @(posedge clk);
      #1;
      stepn++;
      if (sb.size() == 0) begin
         check("sb_empty", 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check("gnt", 32'(gnt_a), 32'(e.gnt_a));
         check("gnt_valid", 32'(gv_a), 32'(|e.gnt_a));
         check("gnt_id", 32'(id_a), 32'(e.id_a));
         if (e.chk_b) begin
            check("gnt_b", 32'(gnt_b), 32'(e.gnt_b));
            check("gnt_valid_b", 32'(gv_b), 32'(|e.gnt_b));
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog step %0d: got timeout expected finish", stepn);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] rot;

      // Reset held with all requests asserted, then idle with no requests.
      step(1, 0, 4'b1111, 4'b0000, 2'd0, 0, 4'b0000);
      step(1, 0, 4'b1111, 4'b0000, 2'd0, 0, 4'b0000);
      step(0, 0, 4'b0000, 4'b0000, 2'd0, 0, 4'b0000);
      step(0, 0, 4'b0000, 4'b0000, 2'd0, 0, 4'b0000);

      // Fixed priority: the highest index wins, and the release hands the
      // grant straight to the next requester with no idle bubble.
      step(0, 0, 4'b0110, 4'b0100, 2'd2, 0, 4'b0000);
      step(0, 0, 4'b0010, 4'b0010, 2'd1, 0, 4'b0000);
      step(0, 0, 4'b0000, 4'b0000, 2'd1, 0, 4'b0000);

      // Round-robin with all requests held. dut_b rotates every cycle;
      // dut_a keeps requester 0 because its hold limit has not been reached.
      step(1, 1, 4'b0000, 4'b0000, 2'd0, 1, 4'b0000);
      for (int k = 0; k < 6; k++) begin
         rot = 4'b0001 << (k % 4);
         step(0, 1, 4'b1111, 4'b0001, 2'd0, 1, rot);
      end
      step(0, 1, 4'b0000, 4'b0000, 2'd0, 0, 4'b0000);

      // Hold limit: requester 0 owns the grant for 8 cycles while req[2]
      // waits, and then the grant moves to requester 2.
      step(1, 1, 4'b0000, 4'b0000, 2'd0, 0, 4'b0000);
      step(0, 1, 4'b0001, 4'b0001, 2'd0, 0, 4'b0000);
      step(0, 1, 4'b0001, 4'b0001, 2'd0, 0, 4'b0000);
      for (int k = 0; k < 6; k++) step(0, 1, 4'b0101, 4'b0001, 2'd0, 0, 4'b0000);
      step(0, 1, 4'b0101, 4'b0100, 2'd2, 0, 4'b0000);
      // A lone requester keeps the grant continuously, past the hold limit.
      for (int k = 0; k < 21; k++) step(0, 1, 4'b0001, 4'b0001, 2'd0, 0, 4'b0000);
      step(0, 1, 4'b0000, 4'b0000, 2'd0, 0, 4'b0000);

      // Wrap-around: a grant to 3 moves the pointer to 0, so req=1001 picks 0.
      step(0, 1, 4'b1000, 4'b1000, 2'd3, 0, 4'b0000);
      step(0, 1, 4'b0000, 4'b0000, 2'd3, 0, 4'b0000);
      step(0, 1, 4'b1001, 4'b0001, 2'd0, 0, 4'b0000);
      // A mode change mid-grant leaves the owner in place. The next
      // arbitration uses fixed priority.
      step(0, 0, 4'b1001, 4'b0001, 2'd0, 0, 4'b0000);
      step(0, 0, 4'b1001, 4'b0001, 2'd0, 0, 4'b0000);
      step(0, 0, 4'b0110, 4'b0100, 2'd2, 0, 4'b0000);

      // Reset mid-grant clears the grant and the pointer. With the pointer
      // at 0, req=1100 picks 2; a stale pointer of 3 would pick 3.
      step(1, 1, 4'b1100, 4'b0000, 2'd0, 0, 4'b0000);
      step(0, 1, 4'b1100, 4'b0100, 2'd2, 0, 4'b0000);
      step(0, 1, 4'b0000, 4'b0000, 2'd2, 0, 4'b0000);
      step(0, 1, 4'b0100, 4'b0100, 2'd2, 0, 4'b0000);
      step(1, 1, 4'b0110, 4'b0000, 2'd0, 0, 4'b0000);
      step(0, 1, 4'b0110, 4'b0010, 2'd1, 0, 4'b0000);
      step(0, 1, 4'b0000, 4'b0000, 2'd1, 0, 4'b0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
